gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_pkg.sv | 16 +
 rtl/gate_ref_model.sv | 25 ++
 rtl/gate_sweep_checker.sv | 99 +++++++++
 tb/tb_gate_sweep_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep checker: expected-function codes on MODE
// and the sequencer state enumeration.
package gate_sweep_pkg;

    localparam logic [1:0] MODE_NAND = 2'd0;
    localparam logic [1:0] MODE_AND  = 2'd1;
    localparam logic [1:0] MODE_NOR  = 2'd2;
    localparam logic [1:0] MODE_OR   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: the value an ideal N_IN-input gate of the
// selected function should produce for stimulus A.
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [1:0]      MODE,
    input  logic [N_IN-1:0] A,
    output logic            EXP
);

    // NOTE: default first so every path assigns EXP and no latch is inferred.
    always_comb begin
        EXP = 1'b0;
        case (MODE)
            MODE_NAND: EXP = ~&A;
            MODE_AND:  EXP = &A;
            MODE_NOR:  EXP = ~|A;
            MODE_OR:   EXP = |A;
            default:   EXP = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of a gate under test against a reference model.
// Define SWEEP_STOP_ON_FAIL_EN to end a sweep at the first mismatch.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 10
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            START,
    input  logic [1:0]      MODE,
    output logic [N_IN-1:0] A,
    input  logic            ZN,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [N_IN:0]   ERR_CNT,
    output logic [N_IN-1:0] FAIL_VEC
);

    localparam int CW = $clog2(SETTLE + 1);

    state_e        state;
    logic [1:0]    mode_q;
    logic [CW-1:0] cnt;
    logic          exp_zn;
    logic          mismatch;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .MODE (mode_q),
        .A    (A),
        .EXP  (exp_zn)
    );

    assign mismatch = (ZN != exp_zn);
    assign PASS     = DONE && (ERR_CNT == '0);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_NAND;
            cnt      <= '0;
            A        <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        mode_q   <= MODE;
                        ERR_CNT  <= '0;
                        FAIL_VEC <= '0;
                        DONE     <= 1'b0;
                        A        <= '0;
                        cnt      <= '0;
                        BUSY     <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        ERR_CNT <= ERR_CNT + (N_IN + 1)'(1);
                        if (ERR_CNT == '0) begin
                            FAIL_VEC <= A;
                        end
                    end
`ifdef SWEEP_STOP_ON_FAIL_EN
                    if (mismatch || (&A)) begin
`else
                    if (&A) begin
`endif
                        state <= ST_IDLE;
                        A     <= '0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        A     <= A + N_IN'(1);
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboarded bench: stimulus queues the expected sweep result, an independent
// monitor compares on every rising edge of DONE.
module tb_gate_sweep_checker;

    localparam int N_IN   = 4;
    localparam int SETTLE = 10;
    localparam int FULL   = (1 << N_IN) * (SETTLE + 1);

    logic            CK = 1'b0;
    logic            RN;
    logic            START;
    logic [1:0]      MODE;
    logic [N_IN-1:0] A;
    logic            ZN;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [N_IN:0]   ERR_CNT;
    logic [N_IN-1:0] FAIL_VEC;

    logic stuck_hi;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        string name;
        int    start;
        int    lat;
        int    err;
        int    fvec;
        int    pass;
    } exp_t;

    exp_t sb_q[$];

    gate_sweep_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .CK       (CK),
        .RN       (RN),
        .START    (START),
        .MODE     (MODE),
        .A        (A),
        .ZN       (ZN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .ERR_CNT  (ERR_CNT),
        .FAIL_VEC (FAIL_VEC)
    );

    // Gate under test: ideal NAND4, optionally with its output stuck at 1.
    assign ZN = stuck_hi ? 1'b1 : ~&A;

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts BUSY cycles and checks each completed sweep.
    initial begin : monitor
        int   busy_cnt;
        logic done_prev;
        exp_t e;
        busy_cnt  = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge CK);
            if (!RN) begin
                busy_cnt  = 0;
                done_prev = 1'b0;
            end else begin
                if (BUSY) busy_cnt++;
                if (DONE && !done_prev) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_latency"}, cyc - e.start, e.lat);
                        check({e.name, "_busy_cycles"}, busy_cnt, e.lat);
                        check({e.name, "_err_cnt"}, int'(ERR_CNT), e.err);
                        check({e.name, "_fail_vec"}, int'(FAIL_VEC), e.fvec);
                        check({e.name, "_pass"}, int'(PASS), e.pass);
                        check({e.name, "_a_idle"}, int'(A), 0);
                    end
                    busy_cnt = 0;
                end
                done_prev = DONE;
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] mode, input logic stuck,
                         input int lat, input int err, input int fvec, input bit push);
        exp_t e;
        @(negedge CK);
        MODE     = mode;
        stuck_hi = stuck;
        START    = 1'b1;
        @(negedge CK);
        START = 1'b0;
        if (push) begin
            e.name  = name;
            e.start = cyc;
            e.lat   = lat;
            e.err   = err;
            e.fvec  = fvec;
            e.pass  = (err == 0) ? 1 : 0;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < FULL + 50 && sb_q.size() != 0; i++) @(negedge CK);
        check({name, "_drained"}, sb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_a"}, int'(A), 0);
        check({name, "_busy"}, int'(BUSY), 0);
        check({name, "_done"}, int'(DONE), 0);
        check({name, "_pass"}, int'(PASS), 0);
        check({name, "_err_cnt"}, int'(ERR_CNT), 0);
        check({name, "_fail_vec"}, int'(FAIL_VEC), 0);
    endtask

    initial begin : stimulus
        int nor_lat, nor_err, and_lat, and_err, or_lat, or_err;
`ifdef SWEEP_STOP_ON_FAIL_EN
        nor_lat = 2 * (SETTLE + 1);  nor_err = 1;
        and_lat = SETTLE + 1;        and_err = 1;
        or_lat  = SETTLE + 1;        or_err  = 1;
`else
        nor_lat = FULL;  nor_err = 14;
        and_lat = FULL;  and_err = 16;
        or_lat  = FULL;  or_err  = 2;
`endif
        RN       = 1'b0;
        START    = 1'b0;
        MODE     = 2'd0;
        stuck_hi = 1'b0;
        repeat (3) @(negedge CK);
        check_all_zero("reset");
        RN = 1'b1;

        // Ideal NAND checked as NAND, then the same gate stuck at 1.
        issue("nand_ideal", 2'd0, 1'b0, FULL, 0, 0, 1'b1);
        drain("nand_ideal");
        issue("nand_stuck1", 2'd0, 1'b1, FULL, 1, 4'b1111, 1'b1);
        drain("nand_stuck1");

        // NAND gate checked against NOR, then results must hold.
        issue("nor_vs_nand", 2'd2, 1'b0, nor_lat, nor_err, 4'b0001, 1'b1);
        drain("nor_vs_nand");
        repeat (20) @(negedge CK);
        check("hold_done", int'(DONE), 1);
        check("hold_err_cnt", int'(ERR_CNT), nor_err);
        check("hold_fail_vec", int'(FAIL_VEC), 4'b0001);
        check("hold_pass", int'(PASS), 0);

        // Every vector mismatches: counter reaches 2^N_IN.
        issue("and_vs_nand", 2'd1, 1'b0, and_lat, and_err, 4'b0000, 1'b1);
        drain("and_vs_nand");
        issue("or_vs_nand", 2'd3, 1'b0, or_lat, or_err, 4'b0000, 1'b1);
        drain("or_vs_nand");

        // Reset at cycle 50 of a sweep aborts it silently.
        issue("abort", 2'd0, 1'b0, FULL, 0, 0, 1'b0);
        repeat (49) @(negedge CK);
        RN = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge CK);
        RN = 1'b1;
        issue("after_reset", 2'd0, 1'b0, FULL, 0, 0, 1'b1);
        drain("after_reset");

        // START and MODE activity mid-sweep must be ignored.
        issue("restart_ignored", 2'd0, 1'b0, FULL, 0, 0, 1'b1);
        repeat (29) @(negedge CK);
        MODE  = 2'd2;
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
        MODE  = 2'd1;
        drain("restart_ignored");

        repeat (5) @(negedge CK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
